word_serializer: RTL and testbench

Parallel-in, serial-out byte serializer. Accepts one NBYTES-wide word per handshake and emits it one byte per cycle, least-significant byte first, on a valid/ready byte stream. It runs in the clk_100M domain and feeds byte-oriented consumers such as shift_reg delay lines and UART/SPI transmit paths. Back-to-back words stream with no idle cycle between them.

---
 rtl/word_serializer_pkg.sv | 11 +
 rtl/word_serializer.sv | 67 ++++++
 tb/tb_word_serializer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared constants and helpers for the word serializer.
package word_serializer_pkg;

  localparam int BYTE_W = 8;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-in, serial-out serializer: one NBYTES-wide word in, one DW-bit symbol
// per cycle out, least-significant symbol first, on a valid/ready stream.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int DW     = BYTE_W
) (
  input  logic                 clk_100M,
  input  logic                 rst,
  input  logic [NBYTES*DW-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic [DW-1:0]        data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 data_last
);

  localparam int CW = cnt_width(NBYTES);

  logic [NBYTES*DW-1:0] sh_q, sh_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 accept;
  logic                 consume;

  // A new word may land on the same edge that drains the final symbol,
  // which is what lets consecutive words stream without a gap.
  assign word_ready = !rst && ((cnt_q == '0) || ((cnt_q == CW'(1)) && data_ready));
  assign accept     = word_valid && word_ready;
  assign consume    = valid_q && data_ready;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (accept) begin
      sh_d  = word_in;
      cnt_d = CW'(NBYTES);
    end else if (consume) begin
      sh_d  = sh_q >> DW;
      cnt_d = cnt_q - CW'(1);
    end
    valid_d = (cnt_d != '0);
    last_d  = (cnt_d == CW'(1));
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_out   = sh_q[DW-1:0];
  assign data_valid = valid_q;
  assign data_last  = last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed and randomized loopback checks for word_serializer.
module tb_word_serializer;

  logic         clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  // NBYTES=4 instance for the directed steps
  logic         rst;
  logic [31:0]  word_in;
  logic         word_valid;
  logic         word_ready;
  logic [7:0]   data_out;
  logic         data_valid;
  logic         data_ready;
  logic         data_last;

  // Shared stimulus for the NBYTES=2 and NBYTES=16 sweep instances
  logic         rst_s;
  logic [127:0] sw_word;
  logic         sw_valid;
  logic         sw_ready;
  logic         d2_wr, d2_valid, d2_last;
  logic [7:0]   d2_out;
  logic         d16_wr, d16_valid, d16_last;
  logic [7:0]   d16_out;

  int vecs  = 0;
  int fails = 0;

  word_serializer #(.NBYTES(4)) u_dut4 (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data_last (data_last)
  );

  word_serializer #(.NBYTES(2)) u_dut2 (
    .clk_100M  (clk_100M),
    .rst       (rst_s),
    .word_in   (sw_word[15:0]),
    .word_valid(sw_valid),
    .word_ready(d2_wr),
    .data_out  (d2_out),
    .data_valid(d2_valid),
    .data_ready(sw_ready),
    .data_last (d2_last)
  );

  word_serializer #(.NBYTES(16)) u_dut16 (
    .clk_100M  (clk_100M),
    .rst       (rst_s),
    .word_in   (sw_word),
    .word_valid(sw_valid),
    .word_ready(d16_wr),
    .data_out  (d16_out),
    .data_valid(d16_valid),
    .data_ready(sw_ready),
    .data_last (d16_last)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic out_chk(input string tag, input logic dv, input logic [7:0] d, input logic dl);
    chk({tag, "_valid"}, data_valid, dv);
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_last"}, data_last, dl);
  endtask

  task automatic tick();
    @(negedge clk_100M);
    #1;
  endtask

  task automatic sweep(input int n);
    logic [127:0] mask, cur, exp_w;
    logic [127:0] sent[$];
    logic         dv, dl, wr, acc;
    logic [7:0]   dout;
    int           words_done, bcnt, cyc;
    mask = (128'd1 << (n * 8)) - 128'd1;
    rst_s = 1'b1; sw_valid = 1'b0; sw_ready = 1'b0; sw_word = '0;
    repeat (2) tick();
    rst_s = 1'b0;
    words_done = 0; bcnt = 0; cyc = 0; cur = '0; acc = 1'b0;
    while (words_done < 1000 && cyc < 60000) begin
      if (acc) sw_valid = 1'b0;
      if (!sw_valid && $urandom_range(0, 3) != 0) begin
        sw_word  = {$urandom, $urandom, $urandom, $urandom} & mask;
        sw_valid = 1'b1;
      end
      sw_ready = ($urandom_range(0, 3) != 0);
      #1;
      dv   = (n == 2) ? d2_valid : d16_valid;
      dl   = (n == 2) ? d2_last  : d16_last;
      wr   = (n == 2) ? d2_wr    : d16_wr;
      dout = (n == 2) ? d2_out   : d16_out;
      acc  = sw_valid && wr;
      if (acc) sent.push_back(sw_word);
      if (dv && sw_ready) begin
        cur = cur | ({120'd0, dout} << (8 * bcnt));
        bcnt++;
        chk($sformatf("sweep%0d_last", n), dl, (bcnt == n));
        if (dl) begin
          chk($sformatf("sweep%0d_pending", n), (sent.size() != 0), 1'b1);
          if (sent.size() != 0) begin
            exp_w = sent.pop_front();
            chk($sformatf("sweep%0d_word", n), cur, exp_w);
          end
          cur = '0; bcnt = 0; words_done++;
        end
      end
      tick();
      cyc++;
    end
    chk($sformatf("sweep%0d_words_done", n), words_done, 1000);
  endtask

  logic [7:0] b2 [8];
  logic       pat [9];
  int         idx;

  initial begin
    rst = 1'b1; word_in = '0; word_valid = 1'b0; data_ready = 1'b0;
    rst_s = 1'b1; sw_word = '0; sw_valid = 1'b0; sw_ready = 1'b0;

    // Reset, then a single word
    repeat (3) begin
      tick();
      chk("rst_word_ready", word_ready, 1'b0);
    end
    out_chk("rst", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_word_ready", word_ready, 1'b1);
    word_in = 32'h44332211; word_valid = 1'b1; data_ready = 1'b1;
    tick(); word_valid = 1'b0;
    out_chk("t1_b0", 1'b1, 8'h11, 1'b0);
    tick(); out_chk("t1_b1", 1'b1, 8'h22, 1'b0);
    tick(); out_chk("t1_b2", 1'b1, 8'h33, 1'b0);
    tick(); out_chk("t1_b3", 1'b1, 8'h44, 1'b1);
    tick(); out_chk("t1_idle", 1'b0, 8'h00, 1'b0);

    // Back-to-back words, second accepted on the edge that drains DD
    b2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66, 8'h77, 8'h88};
    word_in = 32'hDDCCBBAA; word_valid = 1'b1;
    #1;
    chk("t2_word_ready_first", word_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) word_in = 32'h88776655;
      if (i == 4) word_valid = 1'b0;
      #1;
      out_chk($sformatf("t2_b%0d", i), 1'b1, b2[i], (i == 3 || i == 7));
      chk($sformatf("t2_word_ready%0d", i), word_ready, (i == 3 || i == 7));
    end
    tick(); out_chk("t2_idle", 1'b0, 8'h00, 1'b0);

    // Backpressure: data_ready pattern 1,0,0,1,0,1,0,0,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    b2[0] = 8'h11; b2[1] = 8'h22; b2[2] = 8'h33; b2[3] = 8'h44;
    word_in = 32'h44332211; word_valid = 1'b1; data_ready = 1'b0;
    tick(); word_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      data_ready = pat[c];
      #1;
      out_chk($sformatf("t3_c%0d", c), 1'b1, b2[idx], (idx == 3));
      chk($sformatf("t3_word_ready%0d", c), word_ready, (idx == 3 && pat[c]));
      tick();
      if (pat[c]) idx++;
    end
    out_chk("t3_idle", 1'b0, 8'h00, 1'b0);

    // Reset mid-word, then a clean word
    data_ready = 1'b1; word_in = 32'h44332211; word_valid = 1'b1;
    tick(); word_valid = 1'b0;
    out_chk("t4_b0", 1'b1, 8'h11, 1'b0);
    tick(); out_chk("t4_b1", 1'b1, 8'h22, 1'b0);
    tick(); out_chk("t4_b2", 1'b1, 8'h33, 1'b0);
    rst = 1'b1;
    tick();
    out_chk("t4_rst", 1'b0, 8'h00, 1'b0);
    chk("t4_rst_word_ready", word_ready, 1'b0);
    rst = 1'b0; word_in = 32'h0000A5A5; word_valid = 1'b1;
    #1;
    chk("t4_word_ready", word_ready, 1'b1);
    tick(); word_valid = 1'b0;
    out_chk("t4_n0", 1'b1, 8'hA5, 1'b0);
    tick(); out_chk("t4_n1", 1'b1, 8'hA5, 1'b0);
    tick(); out_chk("t4_n2", 1'b1, 8'h00, 1'b0);
    tick(); out_chk("t4_n3", 1'b1, 8'h00, 1'b1);
    tick(); out_chk("t4_idle", 1'b0, 8'h00, 1'b0);

    // Randomized loopback at the parameter extremes
    sweep(2);
    sweep(16);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
